bip_mc_core: RTL and testbench
==============================

Name: bip_mc_core

Overview:
- Parametrised, single-clock successor to the BIP processor.
- Runs the BIP accumulator ISA (5-bit opcode + operand) as a multi-cycle FSM.
- Adds conditional/unconditional jumps, a HALT state, an illegal-opcode flag, a retired-instruction counter and a ready-handshaked data-memory port, so slow memories can stall the core.
- Sits between an external synchronous program ROM and data RAM. No derived clocks.

Parameters:
- DATA_W, 16: accumulator and data-memory word width; must be >= OPND_W.
- OPND_W, 11: operand field width (data address / immediate / jump target).
- PC_W, 11: program counter width.
- CNT_W, 32: retired-instruction counter width.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  PC_W  program address; registered, equals pc.
- imem_data  in  5+OPND_W  instruction; valid one cycle after imem_addr changes (synchronous ROM).
- dmem_addr  out  OPND_W  data address; registered.
- dmem_wdata  out  DATA_W  store data (= acc at issue); registered.
- dmem_re  out  1  read request; held until accepted.
- dmem_we  out  1  write request; held until accepted.
- dmem_ready  in  1  memory accepts request this cycle; for reads, dmem_rdata is valid in the same cycle.
- dmem_rdata  in  DATA_W  read data.
- acc  out  DATA_W  accumulator.
- pc  out  PC_W  program counter.
- halted  out  1  core is in HALT.
- illegal  out  1  sticky: an undefined opcode has executed.
- retired  out  CNT_W  retired-instruction count; saturates at all-ones.

Behaviour:
- Reset (async, immediate): state=FETCH; pc, acc, retired = 0; halted, illegal, dmem_re, dmem_we = 0; dmem_addr, dmem_wdata = 0. An outstanding memory request is dropped. No write may be issued after rst rises.
- Opcodes [instr top 5 bits]:
  - 00000 HLT
  - 00001 STO: M[op]=acc
  - 00010 LD: acc=M[op]
  - 00011 LDI: acc=sext(op)
  - 00100 ADD: acc+=M[op]
  - 00101 ADDI: acc+=sext(op)
  - 00110 SUB: acc-=M[op]
  - 00111 SUBI: acc-=sext(op)
  - 01000 JMP: pc=op
  - 01001 BEQZ: if acc==0 pc=op
  - 01010 BNEZ: if acc!=0 pc=op
  - Others: NOP, set illegal.
- Widths:
  - sext sign-extends OPND_W to DATA_W.
  - Arithmetic is modulo 2^DATA_W; no flags.
  - Jump target is op truncated or zero-extended to PC_W.
  - pc+1 wraps modulo 2^PC_W.
- FSM states FETCH, EXEC, MEM, HALT:
  - FETCH: imem_addr=pc already presented. Next state EXEC.
  - EXEC: decode imem_data.
    - ALU-immediate, jump, branch, NOP: update acc/pc, retired+1, go FETCH. Latency 2 cycles per instruction.
    - LD/ADD/SUB/STO: set dmem_addr=op, dmem_re (or dmem_we with dmem_wdata=acc), go MEM. pc unchanged.
    - HLT: halted=1, retired+1, go HALT. pc not incremented.
  - MEM: hold request and address stable while dmem_ready=0.
    - On dmem_ready=1: drop re/we next edge; update acc for LD/ADD/SUB using dmem_rdata; pc+1; retired+1; go FETCH.
    - Latency 2+N cycles, N >= 1 = cycles spent in MEM.
  - HALT: terminal. Only rst exits. No memory requests; dmem_ready ignored.
- dmem_re and dmem_we are never high together. dmem_ready outside MEM is ignored.
- retired is not incremented once at all-ones.
- Branch taken/not taken: same 2-cycle latency.

Decomposition:
- Package bip_pkg:
  - opcode localparams (OP_HLT..OP_BNEZ);
  - state enum (ST_FETCH, ST_EXEC, ST_MEM, ST_HALT);
  - OPC_W=5.
- One combinational sub-module bip_alu: inputs acc, operand value, add/sub/pass select; output result.
- FSM, pc, counter and registers stay in bip_mc_core.

Test Plan:
1. Program: LDI 5; ADDI -2; STO 7; HLT. Run with dmem_ready tied 1.
   - Required: M[7]=3, acc=3, retired=4, halted=1, pc=3, cycle count 2+2+3+2.
2. LD 4 with M[4]=0x8001, dmem_ready low 3 cycles after request.
   - Required: dmem_re held 4 cycles with stable dmem_addr=4.
   - Required: acc=0x8001 one edge after ready; pc advances by exactly 1.
3. Branch loop: LDI 3; SUBI 1; BNEZ 1; HLT.
   - Required: BNEZ taken twice, falls through once; acc=0; retired=8; halted=1.
4. Opcode 11111 then HLT.
   - Required: illegal=1 and stays 1; acc unchanged; retired=2.
5. Assert rst while in MEM with dmem_we high.
   - Required: dmem_we=0 immediately (before next clk edge); pc=0, acc=0, state FETCH; execution restarts from address 0.
6. PC_W=3: place 8 instructions, no HLT, at addresses 0..7.
   - Required: pc wraps 7->0.
   - With CNT_W=3: retired saturates at 7.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared opcodes, FSM states and ALU selects for the multi-cycle BIP core.
package bip_pkg;

   localparam int OPC_W = 5;

   localparam logic [OPC_W-1:0] OP_HLT  = 5'd0;
   localparam logic [OPC_W-1:0] OP_STO  = 5'd1;
   localparam logic [OPC_W-1:0] OP_LD   = 5'd2;
   localparam logic [OPC_W-1:0] OP_LDI  = 5'd3;
   localparam logic [OPC_W-1:0] OP_ADD  = 5'd4;
   localparam logic [OPC_W-1:0] OP_ADDI = 5'd5;
   localparam logic [OPC_W-1:0] OP_SUB  = 5'd6;
   localparam logic [OPC_W-1:0] OP_SUBI = 5'd7;
   localparam logic [OPC_W-1:0] OP_JMP  = 5'd8;
   localparam logic [OPC_W-1:0] OP_BEQZ = 5'd9;
   localparam logic [OPC_W-1:0] OP_BNEZ = 5'd10;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_EXEC,
      ST_MEM,
      ST_HALT
   } state_e;

   typedef enum logic [1:0] {
      ALU_PASS,
      ALU_ADD,
      ALU_SUB
   } alu_op_e;

endpackage

// File: rtl/bip_mc_core_if.sv
// Program ROM and data RAM bus between the core (master) and memories (slave).
interface bip_mc_core_if #(
   parameter int DATA_W = 16,
   parameter int OPND_W = 11,
   parameter int PC_W   = 11
);
   import bip_pkg::*;

   logic [PC_W-1:0]         imem_addr;
   logic [OPC_W+OPND_W-1:0] imem_data;
   logic [OPND_W-1:0]       dmem_addr;
   logic [DATA_W-1:0]       dmem_wdata;
   logic                    dmem_re;
   logic                    dmem_we;
   logic                    dmem_ready;
   logic [DATA_W-1:0]       dmem_rdata;

   modport master (
      output imem_addr,
      input  imem_data,
      output dmem_addr,
      output dmem_wdata,
      output dmem_re,
      output dmem_we,
      input  dmem_ready,
      input  dmem_rdata
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      input  dmem_addr,
      input  dmem_wdata,
      input  dmem_re,
      input  dmem_we,
      output dmem_ready,
      output dmem_rdata
   );

endinterface

// File: rtl/bip_alu.sv
// Accumulator ALU: pass-through, add or subtract, modulo 2^DATA_W.
module bip_alu
   import bip_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  alu_op_e           op_i,
   output logic [DATA_W-1:0] y_o
);

   always_comb begin
      y_o = b_i;
      unique case (op_i)
         ALU_ADD: y_o = a_i + b_i;
         ALU_SUB: y_o = a_i - b_i;
         default: y_o = b_i;
      endcase
   end

endmodule

// File: rtl/bip_mc_core.sv
// Multi-cycle BIP accumulator core: FETCH/EXEC/MEM/HALT FSM with a
// ready-handshaked data port, jumps, sticky illegal flag and retire counter.
module bip_mc_core
   import bip_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int OPND_W = 11,
   parameter int PC_W   = 11,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   bip_mc_core_if.master     mem,
   output logic [DATA_W-1:0] acc,
   output logic [PC_W-1:0]   pc,
   output logic              halted,
   output logic              illegal,
   output logic [CNT_W-1:0]  retired
);

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]    ret_q, ret_d;
   logic                halted_q, halted_d;
   logic                illegal_q, illegal_d;
   logic                re_q, re_d;
   logic                we_q, we_d;
   logic [OPND_W-1:0]   daddr_q, daddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [OPC_W-1:0]    mop_q, mop_d;

   logic [OPC_W-1:0]    opc;
   logic [OPND_W-1:0]   opnd;
   logic [DATA_W-1:0]   imm;
   logic [PC_W-1:0]     tgt;
   logic [PC_W-1:0]     pc_inc;
   logic [CNT_W-1:0]    ret_inc;
   alu_op_e             alu_op;
   logic [DATA_W-1:0]   alu_b;
   logic [DATA_W-1:0]   alu_y;

   assign opc     = mem.imem_data[OPC_W+OPND_W-1 -: OPC_W];
   assign opnd    = mem.imem_data[OPND_W-1:0];
   assign imm     = DATA_W'($signed(opnd));
   assign tgt     = PC_W'(opnd);
   assign pc_inc  = pc_q + PC_W'(1);
   assign ret_inc = (&ret_q) ? ret_q : ret_q + CNT_W'(1);

   // Memory data feeds the ALU only while a load/add/sub completes.
   always_comb begin
      alu_op = ALU_PASS;
      alu_b  = imm;
      if (state_q == ST_MEM) begin
         alu_b = mem.dmem_rdata;
         if (mop_q == OP_ADD) alu_op = ALU_ADD;
         if (mop_q == OP_SUB) alu_op = ALU_SUB;
      end else if (state_q == ST_EXEC) begin
         if (opc == OP_ADDI) alu_op = ALU_ADD;
         if (opc == OP_SUBI) alu_op = ALU_SUB;
      end
   end

   bip_alu #(.DATA_W(DATA_W)) u_alu (
      .a_i  (acc_q),
      .b_i  (alu_b),
      .op_i (alu_op),
      .y_o  (alu_y)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      acc_d     = acc_q;
      ret_d     = ret_q;
      halted_d  = halted_q;
      illegal_d = illegal_q;
      re_d      = re_q;
      we_d      = we_q;
      daddr_d   = daddr_q;
      wdata_d   = wdata_q;
      mop_d     = mop_q;
      unique case (state_q)
         ST_FETCH: state_d = ST_EXEC;
         ST_EXEC: begin
            state_d = ST_FETCH;
            pc_d    = pc_inc;
            ret_d   = ret_inc;
            case (opc)
               OP_HLT: begin
                  state_d  = ST_HALT;
                  pc_d     = pc_q;
                  halted_d = 1'b1;
               end
               OP_STO: begin
                  state_d = ST_MEM;
                  pc_d    = pc_q;
                  ret_d   = ret_q;
                  we_d    = 1'b1;
                  wdata_d = acc_q;
                  daddr_d = opnd;
                  mop_d   = opc;
               end
               OP_LD, OP_ADD, OP_SUB: begin
                  state_d = ST_MEM;
                  pc_d    = pc_q;
                  ret_d   = ret_q;
                  re_d    = 1'b1;
                  daddr_d = opnd;
                  mop_d   = opc;
               end
               OP_LDI, OP_ADDI, OP_SUBI: acc_d = alu_y;
               OP_JMP:  pc_d = tgt;
               OP_BEQZ: if (acc_q == '0) pc_d = tgt;
               OP_BNEZ: if (acc_q != '0) pc_d = tgt;
               default: illegal_d = 1'b1;
            endcase
         end
         ST_MEM: begin
            if (mem.dmem_ready) begin
               state_d = ST_FETCH;
               re_d    = 1'b0;
               we_d    = 1'b0;
               pc_d    = pc_inc;
               ret_d   = ret_inc;
               if (mop_q != OP_STO) acc_d = alu_y;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         pc_q      <= '0;
         acc_q     <= '0;
         ret_q     <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         re_q      <= 1'b0;
         we_q      <= 1'b0;
         daddr_q   <= '0;
         wdata_q   <= '0;
         mop_q     <= OP_HLT;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         acc_q     <= acc_d;
         ret_q     <= ret_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         re_q      <= re_d;
         we_q      <= we_d;
         daddr_q   <= daddr_d;
         wdata_q   <= wdata_d;
         mop_q     <= mop_d;
      end
   end

   assign mem.imem_addr  = pc_q;
   assign mem.dmem_addr  = daddr_q;
   assign mem.dmem_wdata = wdata_q;
   assign mem.dmem_re    = re_q;
   assign mem.dmem_we    = we_q;

   assign acc     = acc_q;
   assign pc      = pc_q;
   assign halted  = halted_q;
   assign illegal = illegal_q;
   assign retired = ret_q;

endmodule

// File: tb/tb_bip_mc_core.sv
// Directed bench for bip_mc_core: ROM/RAM models with programmable stall,
// plus a narrow PC_W=3 / CNT_W=3 instance for wrap and saturation.
module tb_bip_mc_core;
   import bip_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // main instance
   bip_mc_core_if #(.DATA_W(16), .OPND_W(11), .PC_W(11)) mif ();
   logic [15:0] acc;
   logic [10:0] pc;
   logic        halted, illegal;
   logic [31:0] retired;

   bip_mc_core #(.DATA_W(16), .OPND_W(11), .PC_W(11), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .mem(mif.master),
      .acc(acc), .pc(pc), .halted(halted),
      .illegal(illegal), .retired(retired)
   );

   logic [15:0] rom [0:2047];
   logic [15:0] ram [0:2047];
   int          stall_n = 0;
   int          scnt;
   logic        req;

   assign req = mif.dmem_re | mif.dmem_we;
   assign mif.dmem_ready = (stall_n == 0) ? 1'b1 : (req && scnt >= stall_n);
   assign mif.dmem_rdata = ram[mif.dmem_addr];

   always @(posedge clk) mif.imem_data <= rom[mif.imem_addr];

   always @(posedge clk or posedge rst) begin
      if (rst) scnt <= 0;
      else if (!req) scnt <= 0;
      else scnt <= scnt + 1;
   end

   always @(posedge clk)
      if (!rst && mif.dmem_we && mif.dmem_ready)
         ram[mif.dmem_addr] <= mif.dmem_wdata;

   // narrow instance
   bip_mc_core_if #(.DATA_W(16), .OPND_W(11), .PC_W(3)) nif ();
   logic [15:0] acc2;
   logic [2:0]  pc2;
   logic        halted2, illegal2;
   logic [2:0]  retired2;
   logic [15:0] rom2 [0:7];

   bip_mc_core #(.DATA_W(16), .OPND_W(11), .PC_W(3), .CNT_W(3)) dut2 (
      .clk(clk), .rst(rst), .mem(nif.master),
      .acc(acc2), .pc(pc2), .halted(halted2),
      .illegal(illegal2), .retired(retired2)
   );

   assign nif.dmem_ready = 1'b0;
   assign nif.dmem_rdata = '0;
   always @(posedge clk) nif.imem_data <= rom2[nif.imem_addr];

   function automatic logic [15:0] ins(logic [4:0] o, logic [10:0] a);
      return {o, a};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 2048; i++) begin
         rom[i] = 16'h0000;
         ram[i] = 16'h0000;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_to_halt(output int cyc);
      cyc = 0;
      while (!halted && cyc < 500) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      clear_mem();
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({pc, acc, halted, illegal, mif.dmem_re, mif.dmem_we} !== 29'd0) begin
         failures++;
         $display("FAIL reset_regs got pc=%h acc=%h h=%b i=%b re=%b we=%b exp all 0",
                  pc, acc, halted, illegal, mif.dmem_re, mif.dmem_we);
      end
      checks++;
      if (retired !== 32'd0 || mif.dmem_addr !== 11'd0 ||
          mif.dmem_wdata !== 16'd0 || mif.imem_addr !== 11'd0) begin
         failures++;
         $display("FAIL reset_bus got ret=%h addr=%h wd=%h ia=%h exp 0",
                  retired, mif.dmem_addr, mif.dmem_wdata, mif.imem_addr);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int cyc;
      clear_mem();
      stall_n = 0;
      rom[0] = ins(OP_LDI, 11'd5);
      rom[1] = ins(OP_ADDI, 11'h7FE);
      rom[2] = ins(OP_STO, 11'd7);
      rom[3] = ins(OP_HLT, 11'd0);
      do_reset();
      run_to_halt(cyc);
      checks++;
      if (cyc !== 9) begin
         failures++;
         $display("FAIL basic_cycles got=%0d exp=9", cyc);
      end
      checks++;
      if (ram[7] !== 16'd3) begin
         failures++;
         $display("FAIL basic_mem7 got=%h exp=0003", ram[7]);
      end
      checks++;
      if (acc !== 16'd3 || pc !== 11'd3) begin
         failures++;
         $display("FAIL basic_acc_pc got acc=%h pc=%0d exp acc=0003 pc=3", acc, pc);
      end
      checks++;
      if (retired !== 32'd4 || halted !== 1'b1) begin
         failures++;
         $display("FAIL basic_ret_halt got ret=%0d h=%b exp ret=4 h=1", retired, halted);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (pc !== 11'd3 || retired !== 32'd4 || req !== 1'b0) begin
         failures++;
         $display("FAIL halt_terminal got pc=%0d ret=%0d req=%b exp 3 4 0", pc, retired, req);
      end
   endtask

   task automatic test_stall_load();
      int hold;
      int bound;
      logic addr_ok;
      clear_mem();
      ram[4] = 16'h8001;
      stall_n = 3;
      rom[0] = ins(OP_LD, 11'd4);
      rom[1] = ins(OP_HLT, 11'd0);
      do_reset();
      bound = 0;
      while (!mif.dmem_re && bound < 20) begin
         @(negedge clk);
         bound++;
      end
      hold = 0;
      addr_ok = 1'b1;
      while (mif.dmem_re && hold < 20) begin
         if (mif.dmem_addr !== 11'd4 || mif.dmem_we !== 1'b0) addr_ok = 1'b0;
         hold++;
         @(negedge clk);
      end
      checks++;
      if (hold !== 4) begin
         failures++;
         $display("FAIL stall_re_hold got=%0d exp=4", hold);
      end
      checks++;
      if (addr_ok !== 1'b1) begin
         failures++;
         $display("FAIL stall_addr_stable got=%b exp=1", addr_ok);
      end
      checks++;
      if (acc !== 16'h8001 || pc !== 11'd1) begin
         failures++;
         $display("FAIL stall_ld got acc=%h pc=%0d exp acc=8001 pc=1", acc, pc);
      end
      stall_n = 0;
   endtask

   task automatic test_branch_loop();
      int cyc;
      clear_mem();
      rom[0] = ins(OP_LDI, 11'd3);
      rom[1] = ins(OP_SUBI, 11'd1);
      rom[2] = ins(OP_BNEZ, 11'd1);
      rom[3] = ins(OP_HLT, 11'd0);
      do_reset();
      run_to_halt(cyc);
      checks++;
      if (acc !== 16'd0 || retired !== 32'd8 || halted !== 1'b1) begin
         failures++;
         $display("FAIL loop_state got acc=%h ret=%0d h=%b exp 0 8 1", acc, retired, halted);
      end
      checks++;
      if (cyc !== 16 || pc !== 11'd3) begin
         failures++;
         $display("FAIL loop_timing got cyc=%0d pc=%0d exp cyc=16 pc=3", cyc, pc);
      end
   endtask

   task automatic test_jumps();
      int cyc;
      clear_mem();
      rom[0] = ins(OP_BEQZ, 11'd4);
      rom[4] = ins(OP_LDI, 11'd1);
      rom[5] = ins(OP_BEQZ, 11'd0);
      rom[6] = ins(OP_JMP, 11'd9);
      rom[9] = ins(OP_HLT, 11'd0);
      do_reset();
      run_to_halt(cyc);
      checks++;
      if (pc !== 11'd9 || retired !== 32'd5 || acc !== 16'd1 || cyc !== 10) begin
         failures++;
         $display("FAIL jumps got pc=%0d ret=%0d acc=%h cyc=%0d exp 9 5 0001 10",
                  pc, retired, acc, cyc);
      end
   endtask

   task automatic test_illegal();
      int cyc;
      clear_mem();
      rom[0] = ins(5'b11111, 11'h7FF);
      rom[1] = ins(OP_HLT, 11'd0);
      do_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (illegal !== 1'b1 || acc !== 16'd0 || pc !== 11'd1) begin
         failures++;
         $display("FAIL illegal_set got i=%b acc=%h pc=%0d exp 1 0000 1", illegal, acc, pc);
      end
      run_to_halt(cyc);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (illegal !== 1'b1 || retired !== 32'd2 || acc !== 16'd0) begin
         failures++;
         $display("FAIL illegal_sticky got i=%b ret=%0d acc=%h exp 1 2 0000",
                  illegal, retired, acc);
      end
   endtask

   task automatic test_reset_in_mem();
      int bound;
      int cyc;
      clear_mem();
      ram[9] = 16'hAAAA;
      stall_n = 20;
      rom[0] = ins(OP_LDI, 11'h055);
      rom[1] = ins(OP_STO, 11'd9);
      rom[2] = ins(OP_HLT, 11'd0);
      do_reset();
      bound = 0;
      while (!mif.dmem_we && bound < 20) begin
         @(negedge clk);
         bound++;
      end
      checks++;
      if (mif.dmem_we !== 1'b1 || acc !== 16'h0055) begin
         failures++;
         $display("FAIL rmem_setup got we=%b acc=%h exp 1 0055", mif.dmem_we, acc);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (mif.dmem_we !== 1'b0 || pc !== 11'd0 || acc !== 16'd0 || mif.dmem_addr !== 11'd0) begin
         failures++;
         $display("FAIL rmem_async got we=%b pc=%0d acc=%h addr=%h exp 0 0 0 0",
                  mif.dmem_we, pc, acc, mif.dmem_addr);
      end
      @(negedge clk);
      checks++;
      if (ram[9] !== 16'hAAAA) begin
         failures++;
         $display("FAIL rmem_nowrite got=%h exp=aaaa", ram[9]);
      end
      stall_n = 0;
      rst = 1'b0;
      run_to_halt(cyc);
      checks++;
      if (ram[9] !== 16'h0055 || retired !== 32'd3 || pc !== 11'd2 || cyc !== 7) begin
         failures++;
         $display("FAIL rmem_restart got m9=%h ret=%0d pc=%0d cyc=%0d exp 0055 3 2 7",
                  ram[9], retired, pc, cyc);
      end
   endtask

   task automatic test_wrap_saturate();
      for (int i = 0; i < 8; i++) rom2[i] = ins(OP_ADDI, 11'd1);
      do_reset();
      repeat (14) @(posedge clk);
      #1;
      checks++;
      if (pc2 !== 3'd7 || retired2 !== 3'd7 || acc2 !== 16'd7) begin
         failures++;
         $display("FAIL wrap_pre got pc=%0d ret=%0d acc=%0d exp 7 7 7", pc2, retired2, acc2);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (pc2 !== 3'd0 || retired2 !== 3'd7 || acc2 !== 16'd8) begin
         failures++;
         $display("FAIL wrap_pc got pc=%0d ret=%0d acc=%0d exp 0 7 8", pc2, retired2, acc2);
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (pc2 !== 3'd2 || retired2 !== 3'd7 || acc2 !== 16'd10 || halted2 !== 1'b0) begin
         failures++;
         $display("FAIL wrap_sat got pc=%0d ret=%0d acc=%0d h=%b exp 2 7 10 0",
                  pc2, retired2, acc2, halted2);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rom2[i] = 16'h0000;
      test_reset();
      test_basic();
      test_stall_load();
      test_branch_loop();
      test_jumps();
      test_illegal();
      test_reset_in_mem();
      test_wrap_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
